// File: rtl/mac_pkg.sv
// mac_pkg: shared definitions for the pre-activation MAC array and the
// activation stage that consumes its results.
//   - state_e      : FSM states of the MAC array controller.
//   - MAC_*        : default build constants (vector length, data width, lanes).
//   - acc_width()  : accumulator width that holds N worst-case products plus bias.
package mac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int MAC_N          = 8;
  localparam int MAC_DATA_WIDTH = 8;
  localparam int MAC_LANES      = 4;

  // A signed dw x dw product needs 2*dw bits; summing n of them plus a
  // dw-bit bias grows by at most clog2(n) bits.
  function automatic int acc_width(input int n, input int dw);
    return 2 * dw + $clog2(n);
  endfunction

endpackage

// File: rtl/mac_lane.sv
// mac_lane: one neuron lane -- a signed multiply feeding an accumulator.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset.
//   clear_i     : synchronous zeroing of the accumulator (highest priority).
//   load_i      : first beat, acc = sext(b) + x*w.
//   acc_en_i    : later beat, acc = acc + x*w.
//   x_i, w_i    : signed activation and weight.
//   b_i         : signed bias, used only with load_i.
//   acc_o       : registered accumulator.
module mac_lane import mac_pkg::*; #(
  parameter int DATA_WIDTH = MAC_DATA_WIDTH,
  parameter int ACC_WIDTH  = acc_width(MAC_N, MAC_DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_i,
  input  logic                  load_i,
  input  logic                  acc_en_i,
  input  logic [DATA_WIDTH-1:0] x_i,
  input  logic [DATA_WIDTH-1:0] w_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [ACC_WIDTH-1:0]  acc_o
);

  localparam int PW = 2 * DATA_WIDTH;

  logic signed [PW-1:0]  prod;
  logic [ACC_WIDTH-1:0]  prod_ext;
  logic [ACC_WIDTH-1:0]  bias_ext;
  logic [ACC_WIDTH-1:0]  acc_q;
  logic [ACC_WIDTH-1:0]  acc_d;

  assign prod     = $signed(x_i) * $signed(w_i);
  assign prod_ext = {{(ACC_WIDTH - PW){prod[PW-1]}}, prod};
  assign bias_ext = {{(ACC_WIDTH - DATA_WIDTH){b_i[DATA_WIDTH-1]}}, b_i};

  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (load_i) begin
      acc_d = bias_ext + prod_ext;
    end else if (acc_en_i) begin
      acc_d = acc_q + prod_ext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/mac_preact_array.sv
// mac_preact_array: LANES parallel neuron pre-activations over one streamed
// input vector, each bias + sum(x[i] * w[lane][i]).
// Handshake (both sides): a transfer happens on the rising clk edge where
// valid and ready are both 1; valid holds its payload until that edge, and
// ready may be computed from state alone.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset.
//   clear        : synchronous abort back to IDLE, zeroes results.
//   in_valid/in_ready, in_x, in_w, in_b, in_last : input beat stream.
//   out_valid/out_ready, out_pre, out_err, out_count : result.
//   dbg_state    : current FSM state for observation.
module mac_preact_array import mac_pkg::*; #(
  parameter int N          = MAC_N,
  parameter int DATA_WIDTH = MAC_DATA_WIDTH,
  parameter int LANES      = MAC_LANES,
  parameter int ACC_WIDTH  = acc_width(N, DATA_WIDTH),
  parameter int CNT_WIDTH  = $clog2(N + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_WIDTH-1:0]       in_x,
  input  logic [LANES*DATA_WIDTH-1:0] in_w,
  input  logic [LANES*DATA_WIDTH-1:0] in_b,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*ACC_WIDTH-1:0]  out_pre,
  output logic                        out_err,
  output logic [CNT_WIDTH-1:0]        out_count,
  output logic [1:0]                  dbg_state
);

  state_e               state_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 err_q;

  logic                 beat;
  logic                 first;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic                 at_n;
  logic                 ends;
  logic                 lane_load;
  logic                 lane_acc;

  assign in_ready  = (state_q != ST_DONE);
  assign out_valid = (state_q == ST_DONE);
  assign dbg_state = state_q;

  assign beat  = in_valid & in_ready;
  assign first = (state_q == ST_IDLE);
  // Count after this beat; a vector is forced closed on its Nth beat even
  // without in_last, so later beats open a fresh vector.
  assign cnt_d = first ? CNT_WIDTH'(1) : cnt_q + CNT_WIDTH'(1);
  assign at_n  = (cnt_d == CNT_WIDTH'(N));
  assign ends  = in_last | at_n;

  assign lane_load = beat & first & ~clear;
  assign lane_acc  = beat & (state_q == ST_ACCUM) & ~clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else if (clear) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_ACCUM: begin
          if (beat) begin
            cnt_q <= cnt_d;
            if (ends) begin
              state_q <= ST_DONE;
              err_q   <= ~(in_last & at_n);
            end else begin
              state_q <= ST_ACCUM;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    mac_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .ACC_WIDTH (ACC_WIDTH)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear_i (clear),
      .load_i  (lane_load),
      .acc_en_i(lane_acc),
      .x_i     (in_x),
      .w_i     (in_w[k*DATA_WIDTH +: DATA_WIDTH]),
      .b_i     (in_b[k*DATA_WIDTH +: DATA_WIDTH]),
      .acc_o   (out_pre[k*ACC_WIDTH +: ACC_WIDTH])
    );
  end

  assign out_err   = err_q;
  assign out_count = cnt_q;

endmodule

// File: tb/tb_mac_preact_array.sv
// tb_mac_preact_array: directed vectors for a 2-lane, N=4 MAC array.
// Expected results are hand-computed constants pushed into exp_q when a
// vector is issued; a negedge monitor pops and compares on each output
// handshake.
module tb_mac_preact_array;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int L  = 2;
  localparam int AW = 18;
  localparam int CW = 3;
  localparam int EW = 2 * AW + 1 + CW;

  logic            clk;
  logic            rst_n;
  logic            clear;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_x;
  logic [L*DW-1:0] in_w;
  logic [L*DW-1:0] in_b;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [L*AW-1:0] out_pre;
  logic            out_err;
  logic [CW-1:0]   out_count;
  logic [1:0]      dbg_state;

  mac_preact_array #(.N(N), .DATA_WIDTH(DW), .LANES(L)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_x     (in_x),
    .in_w     (in_w),
    .in_b     (in_b),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pre  (out_pre),
    .out_err  (out_err),
    .out_count(out_count),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] mk(input int p0, input int p1, input bit err, input int cnt);
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [CW-1:0] c;
    a0 = p0[AW-1:0];
    a1 = p1[AW-1:0];
    c  = cnt[CW-1:0];
    return {a1, a0, err, c};
  endfunction

  logic prev_valid = 1'b0;
  int   rise_prev  = 0;
  int   rise_last  = 0;

  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst_n && out_valid && !prev_valid) begin
      rise_prev = rise_last;
      rise_last = cyc;
    end
    prev_valid = out_valid;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("[TB] FAIL unexpected_result: got 0x%0h, required no output",
                 {out_pre, out_err, out_count});
      end else begin
        e = exp_q.pop_front();
        check("result", 64'({out_pre, out_err, out_count}), 64'(e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_beat(input int x, input int w0, input int w1,
                            input int b0, input int b1, input bit last);
    int t;
    in_valid = 1'b1;
    in_x     = x[DW-1:0];
    in_w     = {w1[DW-1:0], w0[DW-1:0]};
    in_b     = {b1[DW-1:0], b0[DW-1:0]};
    in_last  = last;
    t = 0;
    while (!in_ready && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL beat_timeout: got in_ready=0, required 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!(in_ready && !out_valid) && t < 30) begin
      @(posedge clk); #1;
      t++;
    end
    if (!(in_ready && !out_valid)) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL idle_timeout: got out_valid=%0b, required 0", out_valid);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Nominal vector: b={5,-3}, x=1..4, w0=1, w1=-1 -> {15,-13}.
  task automatic send_nominal(input int gap);
    drive_beat(1, 1, -1, 5, -3, 1'b0);
    drive_beat(2, 1, -1, 0, 0, 1'b0);
    idle_cycles(gap);
    drive_beat(3, 1, -1, 0, 0, 1'b0);
    drive_beat(4, 1, -1, 0, 0, 1'b1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_x = '0; in_w = '0;
    in_b = '0; in_last = 1'b0; out_ready = 1'b1;
    idle_cycles(3);
    rst_n = 1'b1;
    idle_cycles(1);

    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_out_pre",   64'(out_pre),   64'(0));
    check("reset_out_err",   64'(out_err),   64'(0));
    check("reset_out_count", 64'(out_count), 64'(0));
    check("reset_in_ready",  64'(in_ready),  64'(1));

    // Nominal, with latency check right after the ending beat.
    exp_q.push_back(mk(15, -13, 1'b0, 4));
    send_nominal(0);
    check("latency_out_valid", 64'(out_valid), 64'(1));
    wait_idle();

    // Extremes.
    exp_q.push_back(mk(65663, 65663, 1'b0, 4));
    for (int i = 0; i < 4; i++) drive_beat(-128, -128, -128, 127, 127, i == 3);
    wait_idle();
    exp_q.push_back(mk(-65152, -65152, 1'b0, 4));
    for (int i = 0; i < 4; i++) drive_beat(-128, 127, 127, -128, -128, i == 3);
    wait_idle();

    // Short vector: in_last on beat 2 -> {5+3, -3-3}.
    exp_q.push_back(mk(8, -6, 1'b1, 2));
    drive_beat(1, 1, -1, 5, -3, 1'b0);
    drive_beat(2, 1, -1, 0, 0, 1'b1);
    wait_idle();

    // Five beats, no in_last: forced close at 4, fifth opens b={1,2}, x=5.
    exp_q.push_back(mk(15, -13, 1'b1, 4));
    exp_q.push_back(mk(6, -3, 1'b1, 1));
    for (int i = 1; i <= 4; i++) drive_beat(i, 1, -1, 5, -3, 1'b0);
    drive_beat(5, 1, -1, 1, 2, 1'b1);
    wait_idle();

    // Bubbles between beats 2 and 3.
    exp_q.push_back(mk(15, -13, 1'b0, 4));
    send_nominal(3);
    wait_idle();

    // Output backpressure for 5 cycles.
    out_ready = 1'b0;
    exp_q.push_back(mk(15, -13, 1'b0, 4));
    send_nominal(0);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold", 64'({out_pre, out_err, out_count}), 64'(mk(15, -13, 1'b0, 4)));
      check("bp_in_ready", 64'({out_valid, in_ready}), 64'(2'b10));
      idle_cycles(1);
    end
    out_ready = 1'b1;
    idle_cycles(1);
    check("bp_release_idle", 64'({out_valid, in_ready}), 64'(2'b01));

    // Clear after beat 2, with a beat offered in the clear cycle.
    drive_beat(1, 1, -1, 5, -3, 1'b0);
    drive_beat(2, 1, -1, 0, 0, 1'b0);
    clear = 1'b1; in_valid = 1'b1; in_x = 8'd7; in_last = 1'b1;
    idle_cycles(1);
    clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    check("clear_pre",   64'(out_pre),   64'(0));
    check("clear_count", 64'(out_count), 64'(0));
    check("clear_state", 64'({out_valid, in_ready}), 64'(2'b01));
    idle_cycles(4);
    check("clear_no_valid", 64'(out_valid), 64'(0));
    exp_q.push_back(mk(4, 4, 1'b0, 4));
    for (int i = 0; i < 4; i++) drive_beat(1, 1, 1, 0, 0, i == 3);
    wait_idle();

    // Asynchronous reset while in DONE.
    out_ready = 1'b0;
    send_nominal(0);
    check("pre_reset_done", 64'(out_valid), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_outputs", 64'({out_valid, out_err, out_count}), 64'(0));
    check("areset_pre", 64'(out_pre), 64'(0));
    check("areset_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle_cycles(1);

    // Back-to-back, out_ready held high.
    exp_q.push_back(mk(15, -13, 1'b0, 4));
    exp_q.push_back(mk(15, -13, 1'b0, 4));
    send_nominal(0);
    send_nominal(0);
    wait_idle();
    idle_cycles(1);
    check("b2b_period", 64'(rise_last - rise_prev), 64'(5));

    idle_cycles(3);
    check("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
